// File: rtl/can_rx_dispatch_if.sv
// Bus between the CAN core / filter registers and the RX dispatcher.
// master = core side driving frames and filter setup, slave = can_rx_dispatch.
interface can_rx_dispatch_if #(
    parameter int NUM_FILT = 4
);
    logic                     i_cen;
    logic                     i_rx_valid;
    logic [127:0]             i_rx_data;
    logic                     i_rx_full;
    logic [NUM_FILT-1:0]      i_filt_en;
    logic [32*NUM_FILT-1:0]   i_filt_mask;
    logic [32*NUM_FILT-1:0]   i_filt_id;
    logic                     i_drop_clr;
    logic [127:0]             o_fifo_data;
    logic                     o_fifo_w_en;
    logic                     o_rx_ok;
    logic                     o_filt_rej;
    logic                     o_rx_ovf;
    logic                     o_rx_lost;
    logic                     o_busy;
    logic [7:0]               o_drop_cnt;

    modport master (
        output i_cen, i_rx_valid, i_rx_data, i_rx_full, i_filt_en, i_filt_mask, i_filt_id, i_drop_clr,
        input  o_fifo_data, o_fifo_w_en, o_rx_ok, o_filt_rej, o_rx_ovf, o_rx_lost, o_busy, o_drop_cnt
    );

    modport slave (
        input  i_cen, i_rx_valid, i_rx_data, i_rx_full, i_filt_en, i_filt_mask, i_filt_id, i_drop_clr,
        output o_fifo_data, o_fifo_w_en, o_rx_ok, o_filt_rej, o_rx_ovf, o_rx_lost, o_busy, o_drop_cnt
    );
endinterface

// File: rtl/can_rx_dispatch.sv
// RX dispatcher: latches decoded CAN frames, runs acceptance filtering and writes accepted frames
// to the RX FIFO. Optional feature macro CAN_RXDISP_TIMESTAMP_EN stamps frame bits [79:64].
module can_rx_dispatch #(
    parameter int NUM_FILT = 4
) (
    input  logic              i_sys_clk,
    input  logic              i_reset,
    can_rx_dispatch_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CHECK, WRITE, DROP} state_t;

    state_t       state, next_state;
    logic [127:0] latch_data;
    logic [127:0] frame_in;
    logic         ovf_flag;
    logic         lost_q;
    logic [7:0]   drop_cnt;
    logic         pass;
    logic         ovf_evt;
    logic         lost_evt;

    function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

`ifdef CAN_RXDISP_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) ts_cnt <= '0;
        else         ts_cnt <= ts_cnt + 16'd1;
    end

    assign frame_in = {bus.i_rx_data[127:80], ts_cnt, bus.i_rx_data[63:0]};
`else
    assign frame_in = bus.i_rx_data;
`endif

    // An empty enable set accepts everything; otherwise any enabled matching filter accepts.
    always_comb begin
        pass = (bus.i_filt_en == '0);
        for (int n = 0; n < NUM_FILT; n++) begin
            if (bus.i_filt_en[n] &&
                ((latch_data[127:96] & bus.i_filt_mask[32*n +: 32]) ==
                 (bus.i_filt_id[32*n +: 32] & bus.i_filt_mask[32*n +: 32])))
                pass = 1'b1;
        end
    end

    assign ovf_evt  = (state == CHECK) && pass && bus.i_rx_full;
    assign lost_evt = bus.i_cen && bus.i_rx_valid && (state != IDLE);

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.i_cen && bus.i_rx_valid) next_state = CHECK;
            CHECK:   next_state = (pass && !bus.i_rx_full) ? WRITE : DROP;
            WRITE:   next_state = IDLE;
            DROP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Frame latch, drop-reason flag, lost pulse and the saturating drop counter.
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            latch_data <= '0;
            ovf_flag   <= 1'b0;
            lost_q     <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (state == IDLE && bus.i_cen && bus.i_rx_valid) latch_data <= frame_in;
            if (state == CHECK) ovf_flag <= ovf_evt;
            lost_q <= lost_evt;
            if (bus.i_drop_clr) drop_cnt <= '0;
            else                drop_cnt <= sat_add(drop_cnt, {1'b0, ovf_evt} + {1'b0, lost_evt});
        end
    end

    always_comb begin
        bus.o_fifo_data = latch_data;
        bus.o_fifo_w_en = (state == WRITE);
        bus.o_rx_ok     = (state == WRITE);
        bus.o_filt_rej  = (state == DROP) && !ovf_flag;
        bus.o_rx_ovf    = (state == DROP) && ovf_flag;
        bus.o_rx_lost   = lost_q;
        bus.o_busy      = (state != IDLE);
        bus.o_drop_cnt  = drop_cnt;
    end
endmodule

// File: tb/tb_can_rx_dispatch.sv
// Directed, table-driven bench for can_rx_dispatch with hand sequences for multi-cycle corners.
module tb_can_rx_dispatch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    can_rx_dispatch_if #(.NUM_FILT(4)) bus ();
    can_rx_dispatch #(.NUM_FILT(4)) dut (.i_sys_clk(clk), .i_reset(rst), .bus(bus));

    int n_pass = 0;
    int n_total = 0;
    int wcnt = 0;
    int exp_cnt = 0;
    logic [15:0] ts_model = '0;
    logic [15:0] ts_exp = '0;

    localparam logic [127:0] D2   = 128'h1234_5678_0000_0008_A5A5A5A5_5A5A5A5A;
    localparam logic [127:0] DREJ = 128'h5000_0000_0000_0004_01020304_05060708;
    localparam logic [127:0] FM   = 128'h00000000_00000000_FFFFFFFF_FFE00000;
    localparam logic [127:0] FI   = 128'h00000000_00000000_50000000_12200000;

    always @(posedge clk) if (bus.o_fifo_w_en) wcnt <= wcnt + 1;
    always @(posedge clk or posedge rst) begin
        if (rst) ts_model <= '0;
        else     ts_model <= ts_model + 16'd1;
    end

    typedef struct {
        logic [3:0]   en;
        logic [127:0] mask;
        logic [127:0] id;
        logic         full;
        logic [127:0] data;
        logic         wen;
        logic         rej;
        logic         ovf;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [127:0] exp_frame(input logic [127:0] d, input logic [15:0] ts);
`ifdef CAN_RXDISP_TIMESTAMP_EN
        return {d[127:80], ts, d[63:0]};
`else
        return d;
`endif
    endfunction

    // Leaves the DUT in the CHECK cycle, 1 time unit after E0.
    task automatic pulse_valid(input logic [127:0] d);
        @(posedge clk); #1;
        ts_exp = ts_model;
        bus.i_rx_data  = d;
        bus.i_rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_rx_valid = 1'b0;
    endtask

    initial begin
        bus.i_cen = 1'b1; bus.i_rx_valid = 1'b0; bus.i_rx_data = '0; bus.i_rx_full = 1'b0;
        bus.i_filt_en = '0; bus.i_filt_mask = '0; bus.i_filt_id = '0; bus.i_drop_clr = 1'b0;

        vecs[0] = '{4'b0000, '0, '0, 1'b0, D2,   1'b1, 1'b0, 1'b0};
        vecs[1] = '{4'b0001, FM, FI, 1'b0, D2,   1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'b0001, FM, FI, 1'b0, DREJ, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{4'b0001, FM, FI, 1'b1, D2,   1'b0, 1'b0, 1'b1};
        vecs[4] = '{4'b0010, FM, FI, 1'b0, DREJ, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'b0101, FM, FI, 1'b0, DREJ, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{4'b0000, '0, '0, 1'b1, D2,   1'b0, 1'b0, 1'b1};

        #2;
        check("reset_busy", bus.o_busy, 0);
        check("reset_wen", bus.o_fifo_w_en, 0);
        check("reset_data", bus.o_fifo_data, 0);
        check("reset_cnt", bus.o_drop_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            bus.i_filt_en = vecs[i].en; bus.i_filt_mask = vecs[i].mask;
            bus.i_filt_id = vecs[i].id; bus.i_rx_full = vecs[i].full;
            pulse_valid(vecs[i].data);
            check($sformatf("v%0d_check_busy", i), bus.o_busy, 1);
            check($sformatf("v%0d_check_wen", i), bus.o_fifo_w_en, 0);
            @(posedge clk); #1;
            if (vecs[i].ovf) exp_cnt++;
            check($sformatf("v%0d_wen", i), bus.o_fifo_w_en, vecs[i].wen);
            check($sformatf("v%0d_ok", i), bus.o_rx_ok, vecs[i].wen);
            check($sformatf("v%0d_rej", i), bus.o_filt_rej, vecs[i].rej);
            check($sformatf("v%0d_ovf", i), bus.o_rx_ovf, vecs[i].ovf);
            if (vecs[i].wen) check($sformatf("v%0d_data", i), bus.o_fifo_data, exp_frame(vecs[i].data, ts_exp));
            @(posedge clk); #1;
            check($sformatf("v%0d_idle", i), bus.o_busy, 0);
            check($sformatf("v%0d_wen_off", i), bus.o_fifo_w_en, 0);
            check($sformatf("v%0d_cnt", i), bus.o_drop_cnt, exp_cnt);
        end
        bus.i_rx_full = 1'b0;

        bus.i_drop_clr = 1'b1; @(posedge clk); #1 bus.i_drop_clr = 1'b0;
        check("clr_cnt", bus.o_drop_cnt, 0);

        // Second valid one cycle after the first: first frame still written.
        bus.i_filt_en = '0;
        @(posedge clk); #1;
        ts_exp = ts_model;
        bus.i_rx_data = D2; bus.i_rx_valid = 1'b1;
        @(posedge clk); #1 bus.i_rx_data = DREJ;
        @(posedge clk); #1 bus.i_rx_valid = 1'b0;
        check("lost_pulse", bus.o_rx_lost, 1);
        check("lost_wen", bus.o_fifo_w_en, 1);
        check("lost_data", bus.o_fifo_data, exp_frame(D2, ts_exp));
        check("lost_cnt", bus.o_drop_cnt, 1);
        @(posedge clk); #1;
        check("lost_pulse_end", bus.o_rx_lost, 0);
        check("lost_idle", bus.o_busy, 0);

        // Overflow and lost in the same cycle count twice.
        bus.i_rx_full = 1'b1;
        @(posedge clk); #1 bus.i_rx_data = D2; bus.i_rx_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 bus.i_rx_valid = 1'b0;
        check("dbl_ovf", bus.o_rx_ovf, 1);
        check("dbl_lost", bus.o_rx_lost, 1);
        check("dbl_cnt", bus.o_drop_cnt, 3);
        @(posedge clk); #1 bus.i_rx_full = 1'b0;

        // Core disabled: valid ignored.
        bus.i_cen = 1'b0;
        pulse_valid(DREJ);
        check("cen0_busy", bus.o_busy, 0);
        @(posedge clk); #1;
        check("cen0_pulses", {bus.o_fifo_w_en, bus.o_filt_rej, bus.o_rx_ovf, bus.o_rx_lost, bus.o_busy}, 0);
        check("cen0_cnt", bus.o_drop_cnt, 3);
        bus.i_cen = 1'b1;

`ifdef CAN_RXDISP_TIMESTAMP_EN
        for (int k = 0; k < 70000 && ts_model != 16'hFFFD; k++) @(posedge clk);
        #1;
        pulse_valid(D2);
        check("ts_pre", ts_exp, 16'hFFFE);
        @(posedge clk); #1;
        check("ts_fffe", bus.o_fifo_data[79:64], 16'hFFFE);
        @(posedge clk); #1;
        pulse_valid(D2);
        @(posedge clk); #1;
        check("ts_wrap", bus.o_fifo_data[79:64], 16'h0002);
        @(posedge clk); #1;
`endif

        // Saturation under a continuous valid stream.
        @(posedge clk); #1 bus.i_rx_data = D2; bus.i_rx_valid = 1'b1;
        repeat (600) @(posedge clk);
        #1 bus.i_rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sat_cnt", bus.o_drop_cnt, 255);
        check("sat_idle", bus.o_busy, 0);

        // Reset during CHECK aborts the frame.
        pulse_valid(D2);
        begin
            int w0;
            w0 = wcnt;
            rst = 1'b1; #1;
            check("rst_mid_busy", bus.o_busy, 0);
            check("rst_mid_cnt", bus.o_drop_cnt, 0);
            @(posedge clk); #1 rst = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("rst_mid_nowrite", wcnt, w0);
            check("rst_mid_idle", bus.o_busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
